pil_cpu_core: RTL and testbench
===============================

Name: pil_cpu_core

Overview:
- Second-generation programmable state machine core: same 8-bit opcode family (MOV/ADD/SUB/INC/shift/jump/LD/ST) with a register and data width of DW.
- New over the first generation: conditional CALL/RET on a hardware return stack, DEC, HALT, a run gate, a req/ack data-memory handshake, and fault reporting.
- Sits between the program BRAM (1-cycle synchronous read) and a data memory/peripheral bus; debug outputs feed the 7-segment display mux.

Parameters:
- DW, 8, width of registers R0..R3, ALU and data bus (4..32).
- PAW, 8, program counter and instruction address width (1..8); jump operand uses its low PAW bits.
- DAW, 8, data-memory address width; address is the low DAW bits of the pointer register, zero-extended if DAW>DW.
- SD, 4, return-stack depth (1..16).

Ports:
- clk  in  1  core clock (CPU clock from divider).
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = execute; 0 = stall in FETCH at the next instruction boundary.
- imem_addr  out  PAW  program address = pc (combinational from pc).
- imem_rdata  in  8  program word for the address presented the previous cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  DAW  data address.
- dmem_wdata  out  DW  store data.
- dmem_ack  in  1  access complete (rdata valid when we=0).
- dmem_rdata  in  DW  load data.
- dbg_sel  in  2  register select for dbg_reg.
- dbg_reg  out  DW  R[dbg_sel].
- dbg_pc  out  PAW  pc.
- dbg_ir  out  8  instruction register.
- flags  out  3  {Z,S,C}.
- halted  out  1  core in HALT.
- fault  out  2  00 none, 01 stack overflow, 10 stack underflow.

Behaviour:
- Encoding is [7:5] op, [3:2] dd, [1:0] ss. The ops are:
  - 000 MOV: dd=ss.
  - 001 ADD: dd=dd+ss.
  - 010 jump/call, format 010_cc_k_xx followed by one target word. cc: 00 always, 01 C, 10 Z, 11 S. k: 0 jump, 1 call.
  - 011 SUB: dd=dd-ss, C=borrow.
  - 100: bit4=0 INC dd; bit4=1 DEC dd. C = carry/borrow out.
  - 101: bit4=0 LD dd,[ss]; bit4=1 ST [dd],ss.
  - 110 SHR: dd=ss>>1, C=ss[0].
  - 111: bit4=0 SHL dd=ss<<1, C=ss[DW-1]. 8'hF0 is RET. 8'hFF is HALT. Other 1111_xxxx codes are NOP.
- Arithmetic is modulo 2^DW. Z and S (bit DW-1) are updated by every register-writing op. C is updated only by ADD, SUB, INC, DEC, SHR and SHL. MOV and LD keep C. Jumps, ST, RET and NOP leave all flags unchanged.
- State machine:
  - FETCH: if run=1, go to DECODE.
  - DECODE: ir<=imem_rdata, pc<=pc+1 (wraps at 2^PAW). Next state: jump group -> TARGET; LD/ST -> MEM; HALT -> HALT; otherwise -> EXEC.
  - EXEC: register write, flag update, or RET pop; then -> FETCH.
  - TARGET: wait for the operand word; -> JEXEC.
  - JEXEC: operand = imem_rdata.
    - Condition false: pc<=pc+1.
    - Condition true, k=0: pc<=operand.
    - Condition true, k=1: push pc+1, then pc<=operand.
    - Then -> FETCH.
  - MEM: hold dmem_req=1 with addr/we/wdata stable until dmem_ack (ack in the same cycle is allowed). A LD writes dd=dmem_rdata and updates Z/S on the ack cycle. -> FETCH.
  - HALT: halted=1. Remain until rst; run is ignored.
- Cycle counts: ALU/RET/NOP 3 cycles; jump/call 4 cycles; LD/ST 3 cycles + ack wait.
- Stack:
  - CALL with the stack full: no push, no jump, fault<=01, enter HALT.
  - RET with the stack empty: fault<=10, enter HALT.
  - RET pops into pc.
- run=0 only takes effect in FETCH. An instruction already in progress, including MEM waits, completes.
- Reset values: pc=0, R0..R3=0, flags=0, ir=0, stack empty, fault=00, halted=0, dmem_req=0, dmem_we=0, state FETCH.
- Reset mid-MEM: dmem_req drops in the next cycle. A late ack is ignored.
- No write to R[x] occurs except in EXEC, JEXEC or a MEM ack cycle.

Test Plan:
- Reset then `MOV/ADD` program: program 0x00:`INC R0` (0x80), 0x01:`ADD R1,R0` (0x24), 0x02:HALT (0xFF) -> R0=1, R1=1, Z=0, halted=1; cycle after reset to halted=1 is 9.
- Carry/zero (DW=8): R0=0xFF, then `INC R0` -> R0=0x00, Z=1, C=1; then `SHR R1,R0` -> R1=0, C=0, Z=1.
- Conditional jump: Z=1, then 0x52,0x10 -> pc=0x10. With Z=0 -> pc = address after the operand. The jump takes 4 cycles either way.
- Call/return with SD=2:
  - CALL 0x20 from 0x05 pushes 0x07; RET at 0x20 resumes at 0x07.
  - A third nested CALL -> fault=01, halted=1, pc unchanged.
  - RET on an empty stack -> fault=10.
- Memory handshake:
  - `ST [R2],R1` with R2=0x30, R1=0xA5 -> dmem_req=1, we=1, addr=0x30, wdata=0xA5, all held stable for 3 ack-delay cycles.
  - `LD R3,[R2]` with rdata=0x80 -> R3=0x80, S=1, C unchanged.
- run gate and reset: run=0 mid-ADD -> ADD completes, then core stalls in FETCH with pc frozen. rst during a MEM wait -> dmem_req=0 next cycle, all registers 0.

Source files
------------

// File: rtl/pil_cpu_core.sv
// Second-generation programmable state machine core: 8-bit opcodes on DW-bit
// registers, call/return stack, req/ack data bus, run gate and fault reporting.
module pil_cpu_core #(
  parameter int unsigned DW  = 8,
  parameter int unsigned PAW = 8,
  parameter int unsigned DAW = 8,
  parameter int unsigned SD  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic [PAW-1:0] imem_addr,
  input  logic [7:0]     imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DAW-1:0] dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  input  logic [1:0]     dbg_sel,
  output logic [DW-1:0]  dbg_reg,
  output logic [PAW-1:0] dbg_pc,
  output logic [7:0]     dbg_ir,
  output logic [2:0]     flags,
  output logic           halted,
  output logic [1:0]     fault
);

  localparam int unsigned SPW = $clog2(SD + 1);
  localparam int unsigned SIW = (SD > 1) ? $clog2(SD) : 1;
  localparam int unsigned SN  = 1 << SIW;

  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_IDC = 3'b100;
  localparam logic [2:0] OP_MEM = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_TARGET, S_JEXEC, S_MEM, S_HALT
  } state_t;

  state_t         state;
  logic [PAW-1:0] pc;
  logic [7:0]     ir;
  logic [DW-1:0]  r [4];
  logic [PAW-1:0] stk [SN];
  logic [SPW-1:0] sp;

  logic [1:0]     dd, ss, dec_dd, dec_ss;
  logic [DW:0]    ext;
  logic [DW-1:0]  alu_res;
  logic           alu_c, alu_wr, alu_cwr, alu_z, alu_s;
  logic           is_ret, cond_ok, ld_z, ld_s;
  logic [DW-1:0]  dec_ptr;

  assign dd        = ir[3:2];
  assign ss        = ir[1:0];
  assign dec_dd    = imem_rdata[3:2];
  assign dec_ss    = imem_rdata[1:0];
  assign dec_ptr   = imem_rdata[4] ? r[dec_dd] : r[dec_ss];
  assign is_ret    = (ir == 8'hF0);
  assign alu_z     = (alu_res == '0);
  assign alu_s     = alu_res[DW-1];
  assign ld_z      = (dmem_rdata == '0);
  assign ld_s      = dmem_rdata[DW-1];

  assign imem_addr = pc;
  assign dbg_pc    = pc;
  assign dbg_ir    = ir;
  assign dbg_reg   = r[dbg_sel];

  // Register-to-register ALU result for the instruction held in ir
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_c   = flags[0];
    alu_wr  = 1'b0;
    alu_cwr = 1'b0;
    case (ir[7:5])
      OP_MOV: begin
        alu_res = r[ss];
        alu_wr  = 1'b1;
      end
      OP_ADD: begin
        ext     = {1'b0, r[dd]} + {1'b0, r[ss]};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
        alu_wr  = 1'b1;
        alu_cwr = 1'b1;
      end
      OP_SUB: begin
        ext     = {1'b0, r[dd]} - {1'b0, r[ss]};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
        alu_wr  = 1'b1;
        alu_cwr = 1'b1;
      end
      OP_IDC: begin
        if (ir[4]) ext = {1'b0, r[dd]} - {{DW{1'b0}}, 1'b1};
        else       ext = {1'b0, r[dd]} + {{DW{1'b0}}, 1'b1};
        alu_res = ext[DW-1:0];
        alu_c   = ext[DW];
        alu_wr  = 1'b1;
        alu_cwr = 1'b1;
      end
      OP_SHR: begin
        alu_res = r[ss] >> 1;
        alu_c   = r[ss][0];
        alu_wr  = 1'b1;
        alu_cwr = 1'b1;
      end
      OP_SHL: begin
        if (!ir[4]) begin
          alu_res = r[ss] << 1;
          alu_c   = r[ss][DW-1];
          alu_wr  = 1'b1;
          alu_cwr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Jump condition select: always, C, Z, S
  always_comb begin
    cond_ok = 1'b1;
    case (ir[4:3])
      2'b01:   cond_ok = flags[0];
      2'b10:   cond_ok = flags[2];
      2'b11:   cond_ok = flags[1];
      default: cond_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ir         <= '0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
      flags      <= '0;
      sp         <= '0;
      fault      <= 2'b00;
      halted     <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        S_FETCH: if (run) state <= S_DECODE;
        S_DECODE: begin
          ir <= imem_rdata;
          pc <= pc + PAW'(1);
          if (imem_rdata == 8'hFF) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (imem_rdata[7:5] == OP_JMP) begin
            state <= S_TARGET;
          end else if (imem_rdata[7:5] == OP_MEM) begin
            dmem_req   <= 1'b1;
            dmem_we    <= imem_rdata[4];
            dmem_addr  <= DAW'(dec_ptr);
            dmem_wdata <= r[dec_ss];
            state      <= S_MEM;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (is_ret) begin
            if (sp == '0) begin
              fault  <= 2'b10;
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              pc <= stk[SIW'(sp - SPW'(1))];
              sp <= sp - SPW'(1);
            end
          end else if (alu_wr) begin
            r[dd] <= alu_res;
            flags <= {alu_z, alu_s, alu_cwr ? alu_c : flags[0]};
          end
        end
        S_TARGET: state <= S_JEXEC;
        S_JEXEC: begin
          state <= S_FETCH;
          if (!cond_ok) begin
            pc <= pc + PAW'(1);
          end else if (!ir[2]) begin
            pc <= PAW'(imem_rdata);
          end else if (sp == SPW'(SD)) begin
            // Full stack: refuse the call and park the core
            fault  <= 2'b01;
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            stk[sp[SIW-1:0]] <= pc + PAW'(1);
            sp               <= sp + SPW'(1);
            pc               <= PAW'(imem_rdata);
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!dmem_we) begin
              r[dd]      <= dmem_rdata;
              flags[2:1] <= {ld_z, ld_s};
            end
            state <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pil_cpu_core.sv
// Directed bench for pil_cpu_core: program BRAM model plus hand-driven data bus.
module tb_pil_cpu_core;

  logic       clk, rst, run;
  logic [7:0] imem_addr, imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_reg, dbg_pc, dbg_ir;
  logic [2:0] flags;
  logic       halted;
  logic [1:0] fault;

  logic [7:0] prog [256];
  int n_assert = 0;
  int n_fail   = 0;

  pil_cpu_core #(.DW(8), .PAW(8), .DAW(8), .SD(2)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dbg_sel(dbg_sel), .dbg_reg(dbg_reg), .dbg_pc(dbg_pc), .dbg_ir(dbg_ir),
    .flags(flags), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= prog[imem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    check(tag, 32'(dbg_reg), exp);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'hFF;
  endtask

  task automatic start();
    rst = 1'b1;
    run = 1'b1;
    dmem_ack = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; run = 1'b1; dmem_ack = 1'b0; dmem_rdata = 8'h00; dbg_sel = 2'd0;
    clear_prog();

    // INC R0; ADD R1,R0; HALT
    prog[0] = 8'h80; prog[1] = 8'h24; prog[2] = 8'hFF;
    start();
    n = 1;
    while (!halted && n < 50) begin
      tick(1);
      n++;
    end
    check("halt_cycle", 32'(n), 32'd9);
    chk_reg("basic_r0", 2'd0, 32'h01);
    chk_reg("basic_r1", 2'd1, 32'h01);
    check("basic_z", 32'(flags[2]), 32'd0);
    check("basic_halted", 32'(halted), 32'd1);

    // Reset from a halted core with non-zero state
    rst = 1'b1;
    tick(1);
    check("rst_pc", 32'(dbg_pc), 32'h00);
    check("rst_ir", 32'(dbg_ir), 32'h00);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    chk_reg("rst_r0", 2'd0, 32'h00);
    chk_reg("rst_r1", 2'd1, 32'h00);

    // DEC R0; INC R0; SHR R1,R0; HALT
    clear_prog();
    prog[0] = 8'h90; prog[1] = 8'h80; prog[2] = 8'hC4;
    start();
    tick(3);
    chk_reg("dec_r0", 2'd0, 32'hFF);
    check("dec_flags", 32'(flags), 32'b011);
    tick(3);
    chk_reg("inc_wrap_r0", 2'd0, 32'h00);
    check("inc_wrap_flags", 32'(flags), 32'b101);
    tick(3);
    chk_reg("shr_r1", 2'd1, 32'h00);
    check("shr_flags", 32'(flags), 32'b100);
    tick(2);
    check("b_halted", 32'(halted), 32'd1);

    // Conditional jump on Z, taken then not taken
    clear_prog();
    prog[8'h00] = 8'h00; prog[8'h01] = 8'h52; prog[8'h02] = 8'h10;
    prog[8'h10] = 8'h80; prog[8'h11] = 8'h52; prog[8'h12] = 8'h40;
    start();
    tick(3);
    check("mov_flags", 32'(flags), 32'b100);
    tick(3);
    check("jz_mid_pc", 32'(dbg_pc), 32'h02);
    tick(1);
    check("jz_taken_pc", 32'(dbg_pc), 32'h10);
    tick(3);
    check("inc_flags", 32'(flags), 32'b000);
    tick(3);
    check("jz_nt_mid_pc", 32'(dbg_pc), 32'h12);
    tick(1);
    check("jz_nt_pc", 32'(dbg_pc), 32'h13);
    tick(2);
    check("c_halted", 32'(halted), 32'd1);

    // Call/return and stack overflow with a 2-deep stack
    clear_prog();
    for (int i = 0; i < 5; i++) prog[i] = 8'hF1;
    prog[8'h05] = 8'h44; prog[8'h06] = 8'h20;
    prog[8'h20] = 8'hF0;
    prog[8'h07] = 8'h44; prog[8'h08] = 8'h30;
    prog[8'h30] = 8'h44; prog[8'h31] = 8'h38;
    prog[8'h38] = 8'h44; prog[8'h39] = 8'h40;
    start();
    tick(15);
    check("nop_pc", 32'(dbg_pc), 32'h05);
    tick(4);
    check("call_pc", 32'(dbg_pc), 32'h20);
    tick(3);
    check("ret_pc", 32'(dbg_pc), 32'h07);
    tick(8);
    check("nest2_pc", 32'(dbg_pc), 32'h38);
    check("nest2_fault", 32'(fault), 32'd0);
    tick(4);
    check("ovf_fault", 32'(fault), 32'b01);
    check("ovf_halted", 32'(halted), 32'd1);
    check("ovf_pc", 32'(dbg_pc), 32'h39);

    // RET with an empty stack
    clear_prog();
    prog[0] = 8'hF0;
    start();
    tick(3);
    check("unf_fault", 32'(fault), 32'b10);
    check("unf_halted", 32'(halted), 32'd1);

    // DEC R0; LD R2,[R0]; LD R1,[R0]; ST [R2],R1; LD R3,[R2]; HALT
    clear_prog();
    prog[0] = 8'h90; prog[1] = 8'hA8; prog[2] = 8'hA4;
    prog[3] = 8'hB9; prog[4] = 8'hAE;
    start();
    dmem_ack = 1'b1;
    dmem_rdata = 8'h30;
    tick(3);
    tick(2);
    check("ld_req", 32'(dmem_req), 32'd1);
    check("ld_we", 32'(dmem_we), 32'd0);
    check("ld_addr", 32'(dmem_addr), 32'hFF);
    tick(1);
    chk_reg("ld_r2", 2'd2, 32'h30);
    check("ld_flags", 32'(flags), 32'b001);
    check("ld_req_drop", 32'(dmem_req), 32'd0);
    dmem_rdata = 8'hA5;
    tick(3);
    chk_reg("ld_r1", 2'd1, 32'hA5);
    dmem_ack = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      check("st_req", 32'(dmem_req), 32'd1);
      check("st_we", 32'(dmem_we), 32'd1);
      check("st_addr", 32'(dmem_addr), 32'h30);
      check("st_wdata", 32'(dmem_wdata), 32'hA5);
      if (i < 2) tick(1);
    end
    dmem_ack = 1'b1;
    tick(1);
    check("st_req_drop", 32'(dmem_req), 32'd0);
    dmem_rdata = 8'h80;
    tick(3);
    chk_reg("ld_r3", 2'd3, 32'h80);
    check("ld_s_keep_c", 32'(flags), 32'b011);
    tick(2);
    check("f_halted", 32'(halted), 32'd1);

    // Run gate mid-ADD, then reset during a MEM wait
    clear_prog();
    prog[0] = 8'h80; prog[1] = 8'h24; prog[2] = 8'hB1;
    start();
    tick(4);
    run = 1'b0;
    tick(2);
    chk_reg("gate_r1", 2'd1, 32'h01);
    check("gate_pc", 32'(dbg_pc), 32'h02);
    tick(5);
    check("stall_pc", 32'(dbg_pc), 32'h02);
    check("stall_ir", 32'(dbg_ir), 32'h24);
    run = 1'b1;
    tick(2);
    check("g_st_req", 32'(dmem_req), 32'd1);
    check("g_st_addr", 32'(dmem_addr), 32'h01);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("rst_mem_req", 32'(dmem_req), 32'd0);
    check("rst_mem_pc", 32'(dbg_pc), 32'h00);
    chk_reg("rst_mem_r0", 2'd0, 32'h00);
    chk_reg("rst_mem_r1", 2'd1, 32'h00);
    dmem_ack = 1'b1;
    rst = 1'b0;
    tick(2);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    chk_reg("late_ack_r0", 2'd0, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
